// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//   Free-running SPI mode-0 transmit master. After reset release it waits
//   IDLE_CYCLES clocks with chip select high. It then latches dataIn and shifts
//   the word out MSB-first, one bit per sclk period. Frames repeat
//   back-to-back with no handshake.
//
// Parameters
//   DATA_WIDTH   bits per frame
//   SCLK_HALF    spi_sclk half-period in clk cycles (>=1)
//   IDLE_CYCLES  clocks spi_CS stays high between frames (>=1)
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous, active-low reset
//   dataIn    in   word to transmit, sampled only on the frame-load edge
//   spi_CS    out  chip select, active low
//   spi_sclk  out  serial clock, idles low
//   spiData   out  serial data (MOSI), MSB first
//   counter   out  sclk rising edges so far in the current frame (0..DATA_WIDTH)
// -----------------------------------------------------------------------------
module spi_master #(
    parameter int DATA_WIDTH  = 16,
    parameter int SCLK_HALF   = 1,
    parameter int IDLE_CYCLES = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_WIDTH-1:0]             dataIn,
    output logic                              spi_CS,
    output logic                              spi_sclk,
    output logic                              spiData,
    output logic [$clog2(DATA_WIDTH+1)-1:0]   counter
);

    localparam int CNT_W  = $clog2(DATA_WIDTH + 1);
    localparam int IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam int HALF_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(SCLK_HALF - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DATA_WIDTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                r_state,    w_state;
    logic [IDLE_W-1:0]     r_idle_cnt, w_idle_cnt;
    logic [HALF_W-1:0]     r_half_cnt, w_half_cnt;
    logic [DATA_WIDTH-1:0] r_shreg,    w_shreg;
    logic                  r_cs,       w_cs;
    logic                  r_sclk,     w_sclk;
    logic                  r_data,     w_data;
    logic [CNT_W-1:0]      r_counter,  w_counter;
    logic [DATA_WIDTH-1:0] w_shift;

    // The MSB of the shift register always mirrors spiData while shifting, so
    // the next bit to drive is the MSB of the left-shifted word.
    assign w_shift = r_shreg << 1;

    always_comb begin
        w_state    = r_state;
        w_idle_cnt = r_idle_cnt;
        w_half_cnt = r_half_cnt;
        w_shreg    = r_shreg;
        w_cs       = r_cs;
        w_sclk     = r_sclk;
        w_data     = r_data;
        w_counter  = r_counter;

        case (r_state)
            ST_IDLE: begin
                if (r_idle_cnt == IDLE_LAST) begin
                    // Frame load: word is captured here and nowhere else.
                    w_idle_cnt = '0;
                    w_half_cnt = '0;
                    w_shreg    = dataIn;
                    w_cs       = 1'b0;
                    w_data     = dataIn[DATA_WIDTH-1];
                    w_counter  = '0;
                    w_state    = ST_SHIFT;
                end else begin
                    w_idle_cnt = r_idle_cnt + 1'b1;
                end
            end

            ST_SHIFT: begin
                if (r_half_cnt == HALF_LAST) begin
                    w_half_cnt = '0;
                    if (!r_sclk) begin
                        // Rising edge: slave samples; data held.
                        w_sclk = 1'b1;
                        if (r_counter < CNT_FULL) begin
                            w_counter = r_counter + 1'b1;
                        end
                    end else begin
                        w_sclk = 1'b0;
                        if (r_counter < CNT_FULL) begin
                            w_shreg = w_shift;
                            w_data  = w_shift[DATA_WIDTH-1];
                        end else begin
                            // Last falling edge: close the frame, counter holds.
                            w_cs    = 1'b1;
                            w_data  = 1'b0;
                            w_state = ST_IDLE;
                        end
                    end
                end else begin
                    w_half_cnt = r_half_cnt + 1'b1;
                end
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_idle_cnt <= '0;
            r_half_cnt <= '0;
            r_shreg    <= '0;
            r_cs       <= 1'b1;
            r_sclk     <= 1'b0;
            r_data     <= 1'b0;
            r_counter  <= '0;
        end else begin
            r_state    <= w_state;
            r_idle_cnt <= w_idle_cnt;
            r_half_cnt <= w_half_cnt;
            r_shreg    <= w_shreg;
            r_cs       <= w_cs;
            r_sclk     <= w_sclk;
            r_data     <= w_data;
            r_counter  <= w_counter;
        end
    end

    assign spi_CS   = r_cs;
    assign spi_sclk = r_sclk;
    assign spiData  = r_data;
    assign counter  = r_counter;

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
//   Drives two spi_master instances: defaults (SCLK_HALF=1, IDLE_CYCLES=2) and
//   SCLK_HALF=2, IDLE_CYCLES=3. A reference model counts clocks since reset
//   release, predicts every output pin per cycle from frame position, and
//   pushes each loaded word into a per-instance queue. A monitor reassembles
//   the serial words at sclk rises and checks them against the queue when
//   chip select returns high.
// -----------------------------------------------------------------------------
module tb_spi_master;

    localparam int D  = 16;
    localparam int H0 = 1;
    localparam int I0 = 2;
    localparam int H1 = 2;
    localparam int I1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1;
    logic [15:0] d0, d1;
    logic        cs0, sclk0, sd0, cs1, sclk1, sd1;
    logic [4:0]  cnt0, cnt1;

    spi_master #(.DATA_WIDTH(D), .SCLK_HALF(H0), .IDLE_CYCLES(I0)) u_dut0 (
        .clk(clk), .reset(rst0), .dataIn(d0),
        .spi_CS(cs0), .spi_sclk(sclk0), .spiData(sd0), .counter(cnt0)
    );

    spi_master #(.DATA_WIDTH(D), .SCLK_HALF(H1), .IDLE_CYCLES(I1)) u_dut1 (
        .clk(clk), .reset(rst1), .dataIn(d1),
        .spi_CS(cs1), .spi_sclk(sclk1), .spiData(sd1), .counter(cnt1)
    );

    int vectors = 0;
    int miscompares = 0;

    function automatic int halfp(input int i);
        return (i == 0) ? H0 : H1;
    endfunction

    function automatic int idlep(input int i);
        return (i == 0) ? I0 : I1;
    endfunction

    // ---------------- reference model (runs on rising edge) ----------------
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    int          n[2]       = '{0, 0};
    logic [15:0] cur_w[2]   = '{16'h0, 16'h0};
    logic        rst_seen[2] = '{1'b0, 1'b0};
    logic        exp_cs[2]  = '{1'b1, 1'b1};
    logic        exp_sclk[2] = '{1'b0, 1'b0};
    logic        exp_sd[2]  = '{1'b0, 1'b0};
    logic [4:0]  exp_cnt[2] = '{5'd0, 5'd0};
    logic        exp_ok[2]  = '{1'b0, 1'b0};

    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                logic        r;
                logic [15:0] din;
                int          hh, ii, f, m, p, t;
                r   = (i == 0) ? rst0 : rst1;
                din = (i == 0) ? d0 : d1;
                hh  = halfp(i);
                ii  = idlep(i);
                f   = ii + 2 * hh * D;
                rst_seen[i] = r;
                if (!r) begin
                    n[i] = 0;
                    if (i == 0) q0.delete(); else q1.delete();
                    exp_cs[i] = 1'b1; exp_sclk[i] = 1'b0; exp_sd[i] = 1'b0; exp_cnt[i] = 5'd0;
                end else begin
                    n[i] = n[i] + 1;
                    m = n[i] - ii;
                    if (m < 0) begin
                        exp_cs[i] = 1'b1; exp_sclk[i] = 1'b0; exp_sd[i] = 1'b0; exp_cnt[i] = 5'd0;
                    end else begin
                        p = m % f;
                        if (p == 0) begin
                            cur_w[i] = din;
                            if (i == 0) q0.push_back(din); else q1.push_back(din);
                        end
                        if (p < 2 * hh * D) begin
                            t = p / hh;
                            exp_cs[i]   = 1'b0;
                            exp_sclk[i] = (t % 2) == 1;
                            exp_cnt[i]  = 5'((t + 1) / 2);
                            exp_sd[i]   = cur_w[i][D - 1 - t / 2];
                        end else begin
                            exp_cs[i] = 1'b1; exp_sclk[i] = 1'b0; exp_sd[i] = 1'b0; exp_cnt[i] = 5'(D);
                        end
                    end
                end
                exp_ok[i] = 1'b1;
            end
        end
    end

    // ---------------- monitor / scoreboard (runs on falling edge) ----------
    logic [15:0] cap[2]      = '{16'h0, 16'h0};
    int          nb[2]       = '{0, 0};
    int          lowcnt[2]   = '{0, 0};
    int          highcnt[2]  = '{0, 0};
    logic        prev_cs[2]  = '{1'b1, 1'b1};
    logic        prev_sclk[2] = '{1'b0, 1'b0};
    logic        had_end[2]  = '{1'b0, 1'b0};
    int          frames_done[2] = '{0, 0};

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                logic        cs, sclk, sd;
                logic [4:0]  cnt;
                logic [15:0] want;
                int          hh;
                cs   = (i == 0) ? cs0 : cs1;
                sclk = (i == 0) ? sclk0 : sclk1;
                sd   = (i == 0) ? sd0 : sd1;
                cnt  = (i == 0) ? cnt0 : cnt1;
                hh   = halfp(i);
                if (exp_ok[i]) begin
                    vectors++;
                    if (cs !== exp_cs[i] || sclk !== exp_sclk[i] || sd !== exp_sd[i] || cnt !== exp_cnt[i]) begin
                        miscompares++;
                        $display("FAIL pins[%0d] n=%0d got cs=%b sclk=%b sd=%b cnt=%0d want cs=%b sclk=%b sd=%b cnt=%0d",
                                 i, n[i], cs, sclk, sd, cnt, exp_cs[i], exp_sclk[i], exp_sd[i], exp_cnt[i]);
                    end
                end
                if (!rst_seen[i]) begin
                    cap[i] = 16'h0; nb[i] = 0; lowcnt[i] = 0; highcnt[i] = 0;
                    prev_cs[i] = 1'b1; prev_sclk[i] = 1'b0; had_end[i] = 1'b0;
                end else begin
                    if (cs) highcnt[i]++; else lowcnt[i]++;
                    if (prev_cs[i] && !cs && had_end[i]) begin
                        vectors++;
                        if (highcnt[i] != idlep(i)) begin
                            miscompares++;
                            $display("FAIL cs_gap[%0d] got %0d clocks want %0d", i, highcnt[i], idlep(i));
                        end
                    end
                    if (!cs && prev_cs[i]) highcnt[i] = 0;
                    if (!prev_sclk[i] && sclk) begin
                        cap[i] = {cap[i][14:0], sd};
                        nb[i]++;
                    end
                    if (!prev_cs[i] && cs) begin
                        vectors++;
                        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                            miscompares++;
                            $display("FAIL frame[%0d] got word %h with no expected word queued", i, cap[i]);
                        end else begin
                            want = (i == 0) ? q0.pop_front() : q1.pop_front();
                            if (cap[i] !== want || nb[i] != D || cnt !== 5'(D) || lowcnt[i] != 2 * hh * D) begin
                                miscompares++;
                                $display("FAIL frame[%0d] got word=%h rises=%0d cnt=%0d cs_low=%0d want word=%h rises=%0d cnt=%0d cs_low=%0d",
                                         i, cap[i], nb[i], cnt, lowcnt[i], want, D, D, 2 * hh * D);
                            end
                        end
                        frames_done[i]++;
                        had_end[i] = 1'b1;
                        cap[i] = 16'h0; nb[i] = 0; lowcnt[i] = 0; highcnt[i] = 1;
                    end
                    prev_cs[i]   = cs;
                    prev_sclk[i] = sclk;
                end
            end
        end
    end

    // ---------------- stimulus ---------------------------------------------
    task automatic wait_neg(input int k);
        for (int j = 0; j < k; j++) @(negedge clk);
    endtask

    initial begin
        rst0 = 1'b0; rst1 = 1'b0;
        d0 = 16'hA569; d1 = 16'hFFFF;
        fork
            begin : stim0
                bit found;
                wait_neg(3);
                rst0 = 1'b1;
                wait_neg(10);
                d0 = 16'h2563;          // mid-frame: A569 still in flight
                wait_neg(35);
                d0 = 16'h9B63;
                wait_neg(34);
                d0 = 16'h6A61;
                // Abort a frame around bit 7 with reset.
                found = 1'b0;
                for (int j = 0; j < 200 && !found; j++) begin
                    @(negedge clk);
                    if (n[0] >= I0 && ((n[0] - I0) % (I0 + 2 * H0 * D)) == 13) found = 1'b1;
                end
                vectors++;
                if (!found) begin
                    miscompares++;
                    $display("FAIL reset_point got no bit-7 position in 200 clocks want one");
                end
                rst0 = 1'b0;
                wait_neg(2);
                rst0 = 1'b1;
                for (int k = 0; k < 150; k++) begin
                    wait_neg($urandom_range(1, 40));
                    d0 = 16'($urandom);
                    if ($urandom_range(0, 15) == 0) begin
                        rst0 = 1'b0;
                        wait_neg($urandom_range(1, 3));
                        rst0 = 1'b1;
                    end
                end
                wait_neg(80);
            end
            begin : stim1
                wait_neg(3);
                rst1 = 1'b1;
                wait_neg(75);           // first frame sends FFFF
                for (int k = 0; k < 80; k++) begin
                    wait_neg($urandom_range(1, 60));
                    d1 = 16'($urandom);
                end
                wait_neg(150);
            end
        join

        vectors++;
        if (frames_done[0] < 20) begin
            miscompares++;
            $display("FAIL frames_done[0] got %0d want >= 20", frames_done[0]);
        end
        vectors++;
        if (frames_done[1] < 20) begin
            miscompares++;
            $display("FAIL frames_done[1] got %0d want >= 20", frames_done[1]);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
